// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Purpose:
//   Shares the CPU's single memory port between instruction fetch (F) and
//   load/store (D). Each access is a request/ack handshake that tolerates a
//   variable number of memory wait states. When both sides request in the
//   same idle cycle, the side that was not granted last wins.
//
// Ports:
//   clock, reset          clock and asynchronous active-low reset
//   f_req/f_addr          fetch request (always a read)
//   f_ack/f_rdata/f_err   fetch completion pulse, read data, timeout flag
//   d_req/d_we/d_addr/d_wdata   load/store request
//   d_ack/d_rdata/d_err   load/store completion pulse, load data, timeout flag
//   mem_req/mem_we/mem_addr/mem_wdata   memory-side request
//   mem_rdata/mem_ready   memory read data and completion strobe
//   busy                  high while an access is in flight or being acked
//   owner_d               1 when D owns (or last owned) the port
//
// Configuration:
//   ARB_TIMEOUT_EN  when defined, an access that sees no mem_ready for
//                   TIMEOUT busy cycles is aborted and acked with err=1.
//                   When undefined, BUSY waits forever and f_err/d_err are 0.
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_ack,
    output logic [DW-1:0] f_rdata,
    output logic          f_err,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          d_err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          busy,
    output logic          owner_d
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic          lastD_q, lastD_d;
    logic          ownerD_q, ownerD_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          we_q, we_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] fRdata_q, fRdata_d;
    logic [DW-1:0] dRdata_q, dRdata_d;
    logic          fErr_q, fErr_d;
    logic          dErr_q, dErr_d;

    logic          grantF;
    logic          grantD;
    logic          timeoutHit;
    logic [DW-1:0] captured;

    // F wins a tie whenever D was the last one granted.
    assign grantF = f_req & (~d_req | lastD_q);
    assign grantD = d_req & ~grantF;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT + 1) < 4) ? 4 : $clog2(TIMEOUT + 1);

    logic [CW-1:0] waitCnt_q, waitCnt_d;

    // waitCnt_q holds the number of earlier busy cycles without mem_ready,
    // so the limit is reached in the busy cycle where it equals TIMEOUT-1.
    assign timeoutHit = (state_q == BUSY) && !mem_ready &&
                        (waitCnt_q == CW'(TIMEOUT - 1));

    // Counter is held at zero outside BUSY, which clears it on entry.
    always_comb begin
        waitCnt_d = waitCnt_q;
        if (state_q != BUSY) begin
            waitCnt_d = '0;
        end else if (!mem_ready) begin
            waitCnt_d = waitCnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            waitCnt_q <= '0;
        end else begin
            waitCnt_q <= waitCnt_d;
        end
    end
`else
    assign timeoutHit = 1'b0;
`endif

    // Reads return memory data; writes report zero back to the requester.
    assign captured = we_q ? '0 : mem_rdata;

    // Next-state and datapath register updates for the three-state handshake.
    always_comb begin
        state_d  = state_q;
        lastD_d  = lastD_q;
        ownerD_d = ownerD_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        fRdata_d = fRdata_q;
        dRdata_d = dRdata_q;
        fErr_d   = fErr_q;
        dErr_d   = dErr_q;

        case (state_q)
            IDLE: begin
                if (grantF || grantD) begin
                    addr_d   = grantD ? d_addr : f_addr;
                    we_d     = grantD & d_we;
                    wdata_d  = grantD ? d_wdata : '0;
                    ownerD_d = grantD;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    if (ownerD_q) begin
                        dRdata_d = captured;
                        dErr_d   = 1'b0;
                    end else begin
                        fRdata_d = captured;
                        fErr_d   = 1'b0;
                    end
                    state_d = DONE;
                end else if (timeoutHit) begin
                    if (ownerD_q) begin
                        dRdata_d = '0;
                        dErr_d   = 1'b1;
                    end else begin
                        fRdata_d = '0;
                        fErr_d   = 1'b1;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                lastD_d = ownerD_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; last-grant resets to D so F wins the first tie.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            lastD_q  <= 1'b1;
            ownerD_q <= 1'b0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            fRdata_q <= '0;
            dRdata_q <= '0;
            fErr_q   <= 1'b0;
            dErr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lastD_q  <= lastD_d;
            ownerD_q <= ownerD_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            fRdata_q <= fRdata_d;
            dRdata_q <= dRdata_d;
            fErr_q   <= fErr_d;
            dErr_q   <= dErr_d;
        end
    end

    // Outputs decode straight from state so an async reset drops them at once.
    assign mem_req   = (state_q == BUSY);
    assign mem_we    = (state_q == BUSY) & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state_q != IDLE);
    assign owner_d   = ownerD_q;
    assign f_ack     = (state_q == DONE) & ~ownerD_q;
    assign d_ack     = (state_q == DONE) & ownerD_q;
    assign f_rdata   = fRdata_q;
    assign d_rdata   = dRdata_q;
    assign f_err     = fErr_q;
    assign d_err     = dErr_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
//
// Purpose:
//   Drives mem_bus_arbiter with directed and random request patterns and
//   compares its outputs with a transaction-level model of the arbitration
//   rules: who wins, what goes to memory, what comes back and when.
//
// Ports: none (top-level bench).
//
// Configuration:
//   ARB_TIMEOUT_EN  when defined, the timeout scenarios are also run.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

    logic        clock;
    logic        reset;
    logic        f_req;
    logic [31:0] f_addr;
    logic        f_ack;
    logic [31:0] f_rdata;
    logic        f_err;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        busy;
    logic        owner_d;

    int checkCount;
    int passCount;

    // Transaction-level model state
    bit          lastD;
    bit          fPend;
    bit          dPend;
    logic [31:0] fAddr;
    logic [31:0] dAddr;
    bit          dWe;
    logic [31:0] dWdata;
    logic [31:0] expFRdata;
    logic [31:0] expDRdata;

    mem_bus_arbiter #(.AW(32), .DW(32), .TIMEOUT(15)) dut (
        .clock    (clock),
        .reset    (reset),
        .f_req    (f_req),
        .f_addr   (f_addr),
        .f_ack    (f_ack),
        .f_rdata  (f_rdata),
        .f_err    (f_err),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_ack    (d_ack),
        .d_rdata  (d_rdata),
        .d_err    (d_err),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .busy     (busy),
        .owner_d  (owner_d)
    );

    // 10 ns clock; the bench drives and samples on the falling edge.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    task automatic raiseF(input logic [31:0] addr);
        if (!fPend) begin
            fPend  = 1'b1;
            fAddr  = addr;
            f_req  = 1'b1;
            f_addr = addr;
        end
    endtask

    task automatic raiseD(input bit we, input logic [31:0] addr, input logic [31:0] data);
        if (!dPend) begin
            dPend   = 1'b1;
            dWe     = we;
            dAddr   = addr;
            dWdata  = data;
            d_req   = 1'b1;
            d_we    = we;
            d_addr  = addr;
            d_wdata = data;
        end
    endtask

    // Model reaction to reset: nothing pending, no data held, D counts as last.
    task automatic modelReset();
        lastD     = 1'b1;
        fPend     = 1'b0;
        dPend     = 1'b0;
        expFRdata = '0;
        expDRdata = '0;
    endtask

    // One complete access. Called at a falling edge in IDLE with the requests
    // already applied; returns at the falling edge of the following IDLE cycle.
    task automatic applyStimulus(input int waits, input logic [31:0] rd);
        bit          winD;
        logic [31:0] eAddr;
        bit          eWe;
        logic [31:0] eWdata;
        logic [31:0] eRdata;

        winD   = dPend && (!fPend || !lastD);
        eAddr  = winD ? dAddr : fAddr;
        eWe    = winD && dWe;
        eWdata = dWdata;

        @(negedge clock);
        checkOutput("memReqRise", mem_req, 1'b1);
        checkOutput("ownerD", owner_d, winD);

        // The winner lets go and scribbles on its operands; the access must not notice.
        if (winD) begin
            dPend   = 1'b0;
            d_req   = 1'b0;
            d_we    = 1'($urandom);
            d_addr  = $urandom;
            d_wdata = $urandom;
        end else begin
            fPend  = 1'b0;
            f_req  = 1'b0;
            f_addr = $urandom;
        end

        for (int i = 0; i <= waits; i++) begin
            mem_ready = (i == waits);
            mem_rdata = (i == waits) ? rd : $urandom;
            checkOutput("busyMemReq", mem_req, 1'b1);
            checkOutput("busyAddr", mem_addr, eAddr);
            checkOutput("busyWe", mem_we, eWe);
            if (eWe) begin
                checkOutput("busyWdata", mem_wdata, eWdata);
            end
            checkOutput("busyNoAck", {f_ack, d_ack}, 2'b00);
            @(negedge clock);
        end

        eRdata = eWe ? 32'h0 : rd;
        checkOutput("doneMemReq", mem_req, 1'b0);
        checkOutput("doneBusy", busy, 1'b1);
        checkOutput("doneAcks", {f_ack, d_ack}, {!winD, winD});
        if (winD) begin
            expDRdata = eRdata;
        end else begin
            expFRdata = eRdata;
        end
        checkOutput("fRdata", f_rdata, expFRdata);
        checkOutput("dRdata", d_rdata, expDRdata);
        checkOutput("errs", {f_err, d_err}, 2'b00);
        lastD = winD;

        // Memory noise while not busy must be ignored.
        mem_ready = 1'($urandom);
        mem_rdata = $urandom;
        @(negedge clock);
        mem_ready = 1'b0;
        checkOutput("idleAcks", {f_ack, d_ack, busy}, 3'b000);
        checkOutput("idleFRdata", f_rdata, expFRdata);
        checkOutput("idleDRdata", d_rdata, expDRdata);
    endtask

`ifdef ARB_TIMEOUT_EN
    // A D load that sees no ready for 15 busy cycles, or ready only on the 15th.
    task automatic doTimeout(input bit readyOnLast);
        logic [31:0] rd;
        rd = $urandom;
        raiseD(1'b0, $urandom, $urandom);
        @(negedge clock);
        dPend = 1'b0;
        d_req = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            mem_ready = readyOnLast && (k == 15);
            mem_rdata = rd;
            checkOutput("toMemReq", mem_req, 1'b1);
            @(negedge clock);
        end
        mem_ready = 1'b0;
        expDRdata = readyOnLast ? rd : 32'h0;
        checkOutput("toMemReqDrop", mem_req, 1'b0);
        checkOutput("toAck", d_ack, 1'b1);
        checkOutput("toErr", d_err, !readyOnLast);
        checkOutput("toRdata", d_rdata, expDRdata);
        lastD = 1'b1;
        @(negedge clock);
        checkOutput("toIdle", {d_ack, busy}, 2'b00);
    endtask
`endif

    initial begin
        checkCount = 0;
        passCount  = 0;
        f_req      = 1'b0;
        f_addr     = '0;
        d_req      = 1'b0;
        d_we       = 1'b0;
        d_addr     = '0;
        d_wdata    = '0;
        mem_rdata  = '0;
        mem_ready  = 1'b0;
        reset      = 1'b0;
        modelReset();

        // Reset held with a fetch pending: everything stays at zero.
        raiseF(32'h100);
        repeat (2) @(negedge clock);
        checkOutput("rstFlags",
                    {f_ack, f_err, d_ack, d_err, mem_req, mem_we, busy, owner_d}, 8'h00);
        checkOutput("rstRdata", {f_rdata, d_rdata}, 64'h0);
        checkOutput("rstMem", {mem_addr, mem_wdata}, 64'h0);

        // Release, then a zero-wait fetch of 0x100.
        reset = 1'b1;
        applyStimulus(0, 32'hDEADBEEF);

        // Store to 0x20 with four wait states.
        raiseD(1'b1, 32'h20, 32'h55);
        applyStimulus(4, $urandom);

        // Reset in the middle of a busy fetch.
        raiseF($urandom);
        @(negedge clock);
        checkOutput("midMemReq", mem_req, 1'b1);
        #2 reset = 1'b0;
        #1;
        checkOutput("midRstDrop", {mem_req, busy, f_ack, d_ack}, 4'b0000);
        f_req = 1'b0;
        modelReset();
        @(negedge clock);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clock);
            checkOutput("postRstIdle", {busy, f_ack, d_ack}, 3'b000);
        end

        // Both sides held after reset: grants must alternate F, D, F, D.
        for (int n = 0; n < 4; n++) begin
            raiseF($urandom);
            raiseD(1'($urandom), $urandom, $urandom);
            applyStimulus($urandom_range(0, 3), $urandom);
        end

`ifdef ARB_TIMEOUT_EN
        doTimeout(1'b0);
        doTimeout(1'b1);
`endif

        // Random mix of single and simultaneous requests.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) == 1) raiseF($urandom);
            if ($urandom_range(0, 1) == 1) raiseD(1'($urandom), $urandom, $urandom);
            if (!fPend && !dPend) raiseF($urandom);
            applyStimulus($urandom_range(0, 6), $urandom);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
